// File: rtl/rx_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding, idle line
// level and the mid-bit sample-point helper.
package rx_pkg;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    INICIO      = 3'd1,
    DADOS       = 3'd2,
    PARIDADE    = 3'd3,
    PARADA      = 3'd4,
    ESPERA_ALTO = 3'd5
  } estado_t;

  localparam logic RX_IDLE_LEVEL = 1'b1;

  // Number of clock cycles from the start edge to the centre of a bit.
  function automatic int ponto_amostra(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/receptor_serial_sincronizador.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops preset
// to the idle level so reset never produces a false start edge.
module sincronizador_rx
  import rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q_sync
);

  logic meta_r;
  logic sync_r;

  // Double-register the line to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RX_IDLE_LEVEL;
      sync_r <= RX_IDLE_LEVEL;
    end else begin
      meta_r <= d_async;
      sync_r <= meta_r;
    end
  end

  assign q_sync = sync_r;

endmodule

// File: rtl/receptor_serial.sv
// Serial-to-parallel UART-style receiver feeding the 8-bit register.
// Good words appear on Dado with a one-cycle Valido; framing and parity
// problems pulse ErroQuadro / ErroParidade and leave Dado untouched.
// Optional feature macro: RX_PARITY_EN (adds an even-parity bit, 11-bit frame).
module receptor_serial
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Rx,
  output logic [DATA_W-1:0] Dado,
  output logic              Valido,
  output logic              ErroQuadro,
  output logic              ErroParidade,
  output logic              Ocupado
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(ponto_amostra(CLKS_PER_BIT) - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_W - 1);

  logic              rx_s;
  logic              rx_prev_r;
  estado_t           estado_r;
  logic [CW-1:0]     cnt_r;
  logic [BW-1:0]     bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_err_r;

`ifdef RX_PARITY_EN
  // Even parity: returns 1 when data bits plus parity bit have odd weight.
  function automatic logic paridade_errada(input logic [DATA_W-1:0] dados,
                                           input logic bit_par);
    return ^{dados, bit_par};
  endfunction
`endif

  sincronizador_rx u_sinc (
    .clk     (Clk),
    .rst_n   (Reset),
    .d_async (Rx),
    .q_sync  (rx_s)
  );

  // Receiver FSM with bit timing, bit counting, shifting and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rx_prev_r    <= RX_IDLE_LEVEL;
      estado_r     <= OCIOSO;
      cnt_r        <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      par_err_r    <= 1'b0;
      Dado         <= '0;
      Valido       <= 1'b0;
      ErroQuadro   <= 1'b0;
      ErroParidade <= 1'b0;
      Ocupado      <= 1'b0;
    end else begin
      rx_prev_r    <= rx_s;
      Valido       <= 1'b0;
      ErroQuadro   <= 1'b0;
      ErroParidade <= 1'b0;
      case (estado_r)
        OCIOSO: begin
          cnt_r     <= '0;
          bit_cnt_r <= '0;
          if ((rx_prev_r == RX_IDLE_LEVEL) && (rx_s != RX_IDLE_LEVEL)) begin
            estado_r  <= INICIO;
            par_err_r <= 1'b0;
            Ocupado   <= 1'b1;
          end else begin
            Ocupado <= 1'b0;
          end
        end
        INICIO: begin
          if (cnt_r == CNT_MID) begin
            // Realign so later samples land mid-bit.
            cnt_r <= '0;
            if (rx_s != RX_IDLE_LEVEL) begin
              estado_r <= DADOS;
            end else begin
              estado_r <= OCIOSO;
              Ocupado  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DADOS: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            shift_r <= {rx_s, shift_r[DATA_W-1:1]};
            if (bit_cnt_r == BITS_LAST) begin
              bit_cnt_r <= '0;
`ifdef RX_PARITY_EN
              estado_r  <= PARIDADE;
`else
              estado_r  <= PARADA;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        PARIDADE: begin
`ifdef RX_PARITY_EN
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= '0;
            par_err_r <= paridade_errada(shift_r, rx_s);
            estado_r  <= PARADA;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
`else
          // Unreachable without parity support; recover to idle.
          cnt_r    <= '0;
          estado_r <= OCIOSO;
          Ocupado  <= 1'b0;
`endif
        end
        PARADA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (rx_s == RX_IDLE_LEVEL) begin
              if (!par_err_r) begin
                Dado   <= shift_r;
                Valido <= 1'b1;
              end else begin
                ErroParidade <= 1'b1;
              end
              estado_r <= OCIOSO;
              Ocupado  <= 1'b0;
            end else begin
              // A parity error in the same frame pulses alongside the framing error.
              ErroQuadro   <= 1'b1;
              ErroParidade <= par_err_r;
              estado_r     <= ESPERA_ALTO;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ESPERA_ALTO: begin
          cnt_r <= '0;
          if (rx_s == RX_IDLE_LEVEL) begin
            estado_r <= OCIOSO;
            Ocupado  <= 1'b0;
          end else begin
            estado_r <= ESPERA_ALTO;
          end
        end
        default: begin
          cnt_r     <= '0;
          bit_cnt_r <= '0;
          estado_r  <= OCIOSO;
          Ocupado   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_serial.sv
// Self-checking bench for receptor_serial (CLKS_PER_BIT=4). Frames are built
// bit by bit on Rx; a frame-level reference model predicts which words must
// appear and how many error pulses are due. Build with and without RX_PARITY_EN.
module tb_receptor_serial;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Rx = 1'b1;
  logic [DW-1:0] Dado;
  logic          Valido, ErroQuadro, ErroParidade, Ocupado;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int got_fe, got_pe, got_both;
  int exp_fe, exp_pe, exp_both;
  logic [DW-1:0] last_good = '0;

  always #5 Clk = ~Clk;

  receptor_serial #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Rx           (Rx),
    .Dado         (Dado),
    .Valido       (Valido),
    .ErroQuadro   (ErroQuadro),
    .ErroParidade (ErroParidade),
    .Ocupado      (Ocupado)
  );

  // Observe output pulses away from the active edge; every high cycle counts.
  always @(negedge Clk) begin
    if (Reset) begin
      if (Valido) got_q.push_back(Dado);
      if (ErroQuadro) got_fe++;
      if (ErroParidade) got_pe++;
      if (ErroQuadro && ErroParidade) got_both++;
    end
  end

  task automatic clear_obs();
    got_q.delete(); exp_q.delete();
    got_fe = 0; got_pe = 0; got_both = 0;
    exp_fe = 0; exp_pe = 0; exp_both = 0;
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (CPB) @(negedge Clk);
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  // Reference model: outcome of a whole frame from its bit values.
  task automatic model_frame(input logic [DW-1:0] d, input logic par_ok, input logic stop);
    logic pbad;
    pbad = PAR_EN && !par_ok;
    if (!stop) begin
      exp_fe++;
      if (pbad) begin exp_pe++; exp_both++; end
    end else if (pbad) begin
      exp_pe++;
    end else begin
      exp_q.push_back(d);
      last_good = d;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par_ok, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_ok ? ^d : ~^d);
    drive_bit(stop);
    Rx = 1'b1;
    model_frame(d, par_ok, stop);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (Ocupado === 1'b1 && k < 400) begin
      @(negedge Clk);
      k++;
    end
    checks++;
    if (Ocupado !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout: Ocupado=%b after %0d cycles, required 0", tag, Ocupado, k);
    end
    idle(2);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Rx = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({Dado, Valido, ErroQuadro, ErroParidade, Ocupado} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h, required 0", {Dado, Valido, ErroQuadro, ErroParidade, Ocupado});
    end
    Reset = 1'b1;
    idle(5);
    checks++;
    if ({Dado, Valido, ErroQuadro, ErroParidade, Ocupado} !== '0) begin
      errors++;
      $display("FAIL reset_release: outputs=%h, required 0", {Dado, Valido, ErroQuadro, ErroParidade, Ocupado});
    end
  endtask

  task automatic test_single();
    clear_obs();
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(2 * CPB);
    wait_idle("single");
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_word: count=%0d first=%h, required 1 word A5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
    checks++;
    if (got_fe != 0 || got_pe != 0) begin
      errors++;
      $display("FAIL single_err: fe=%0d pe=%0d, required 0 0", got_fe, got_pe);
    end
    checks++;
    if (Dado !== 8'hA5) begin
      errors++;
      $display("FAIL single_dado: Dado=%h, required A5", Dado);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(2 * CPB);
    wait_idle("b2b");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (Dado !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_dado: Dado=%h, required FF", Dado);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    Rx = 1'b0;
    @(negedge Clk);
    Rx = 1'b1;
    idle(4 * CPB);
    wait_idle("glitch");
    checks++;
    if (got_q.size() != 0 || got_fe != 0 || got_pe != 0) begin
      errors++;
      $display("FAIL glitch_pulses: words=%0d fe=%0d pe=%0d, required none", got_q.size(), got_fe, got_pe);
    end
    checks++;
    if (Dado !== last_good) begin
      errors++;
      $display("FAIL glitch_dado: Dado=%h, required %h", Dado, last_good);
    end
  endtask

  task automatic test_break();
    clear_obs();
    send_frame(8'h55, 1'b1, 1'b0);
    Rx = 1'b0;
    repeat (40) @(negedge Clk);
    checks++;
    if (Dado !== last_good) begin
      errors++;
      $display("FAIL break_dado: Dado=%h, required %h", Dado, last_good);
    end
    idle(2 * CPB);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(2 * CPB);
    wait_idle("break");
    checks++;
    if (got_fe != exp_fe) begin
      errors++;
      $display("FAIL break_fe: got %0d pulses, required %0d", got_fe, exp_fe);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
      errors++;
      $display("FAIL break_recover: count=%0d first=%h, required 1 word 81", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    clear_obs();
    d = 8'h0F;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    Reset = 1'b0;
    #1;
    checks++;
    if ({Dado, Valido, ErroQuadro, ErroParidade, Ocupado} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: outputs=%h, required 0", {Dado, Valido, ErroQuadro, ErroParidade, Ocupado});
    end
    last_good = '0;
    Rx = 1'b1;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    idle(12 * CPB);
    checks++;
    if (got_q.size() != 0 || got_fe != 0 || got_pe != 0) begin
      errors++;
      $display("FAIL midreset_silent: words=%0d fe=%0d pe=%0d, required none", got_q.size(), got_fe, got_pe);
    end
    send_frame(8'h12, 1'b1, 1'b1);
    idle(2 * CPB);
    wait_idle("midreset");
    checks++;
    if (got_q.size() != 1 || Dado !== 8'h12) begin
      errors++;
      $display("FAIL midreset_next: count=%0d Dado=%h, required 1 word 12", got_q.size(), Dado);
    end
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    clear_obs();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(2 * CPB);
    checks++;
    if (got_pe != 1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL parity_bad: pe=%0d words=%0d, required 1 0", got_pe, got_q.size());
    end
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    checks++;
    if (got_q.size() != 1 || Dado !== 8'h07) begin
      errors++;
      $display("FAIL parity_good: words=%0d Dado=%h, required 1 07", got_q.size(), Dado);
    end
    send_frame(8'hC1, 1'b0, 1'b0);
    idle(3 * CPB);
    wait_idle("parity");
    checks++;
    if (got_both != exp_both || got_fe != exp_fe || got_pe != exp_pe) begin
      errors++;
      $display("FAIL parity_both: both=%0d fe=%0d pe=%0d, required %0d %0d %0d", got_both, got_fe, got_pe, exp_both, exp_fe, exp_pe);
    end
    checks++;
    if (Dado !== 8'h07) begin
      errors++;
      $display("FAIL parity_dado: Dado=%h, required 07", Dado);
    end
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] d;
    logic stop, pok;
    clear_obs();
    for (int n = 0; n < 14; n++) begin
      d    = DW'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pok  = ($urandom_range(0, 3) != 0);
      send_frame(d, pok, stop);
      if (!stop) idle(2 * CPB);
      else idle($urandom_range(0, 2) * CPB);
    end
    idle(2 * CPB);
    wait_idle("random");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (got_fe != exp_fe || got_pe != exp_pe || got_both != exp_both) begin
      errors++;
      $display("FAIL rand_errs: fe=%0d pe=%0d both=%0d, required %0d %0d %0d", got_fe, got_pe, got_both, exp_fe, exp_pe, exp_both);
    end
    checks++;
    if (Dado !== last_good) begin
      errors++;
      $display("FAIL rand_dado: Dado=%h, required %h", Dado, last_good);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
